// File: rtl/gpio_pkg.sv
// +--------------------------------------------------------------------+
// | gpio_pkg : register address map shared by the GPIO controller      |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package gpio_pkg;

  typedef logic [2:0] gpio_addr_t;

  localparam logic [2:0] GPIO_ADDR_DATA_OUT   = 3'd0;
  localparam logic [2:0] GPIO_ADDR_DIR        = 3'd1;
  localparam logic [2:0] GPIO_ADDR_DATA_IN    = 3'd2;
  localparam logic [2:0] GPIO_ADDR_RISE_EN    = 3'd3;
  localparam logic [2:0] GPIO_ADDR_FALL_EN    = 3'd4;
  localparam logic [2:0] GPIO_ADDR_IRQ_STATUS = 3'd5;
  localparam logic [2:0] GPIO_ADDR_DATA_SET   = 3'd6;
  localparam logic [2:0] GPIO_ADDR_DATA_CLR   = 3'd7;

endpackage

`default_nettype wire

// File: rtl/gpio_sync.sv
// +--------------------------------------------------------------------+
// | gpio_sync : multi-stage vector synchroniser for asynchronous pads  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module gpio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign dout = stages[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/gpio_ctrl.sv
// +--------------------------------------------------------------------+
// | gpio_ctrl : register-mapped GPIO with edge capture and interrupt   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reg_we,
  input  logic             reg_re,
  input  gpio_addr_t       reg_addr,
  input  logic [WIDTH-1:0] reg_wdata,
  output logic [WIDTH-1:0] reg_rdata,
  output logic             reg_rvalid,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam int             CNT_W     = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] ARMED_CNT = CNT_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] prev_in;
  logic [CNT_W-1:0] warm_cnt;
  logic             armed;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] w1c_mask;
  logic [WIDTH-1:0] rd_mux;

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (gpio_in),
    .dout  (sync_in)
  );

  // Edge history and warm-up: the counter keeps the reset-to-pad transition
  // of pins already high at release from being reported as a rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_in  <= '0;
      warm_cnt <= '0;
    end else begin
      prev_in <= sync_in;
      if (warm_cnt != ARMED_CNT) begin
        warm_cnt <= warm_cnt + 1'b1;
      end
    end
  end

  assign armed = (warm_cnt == ARMED_CNT);
  assign rise  = sync_in & ~prev_in;
  assign fall  = ~sync_in & prev_in;
  assign hit   = ((rise & rise_en) | (fall & fall_en)) & ~dir & {WIDTH{armed}};

  always_comb begin
    w1c_mask = '0;
    if (reg_we && reg_addr == GPIO_ADDR_IRQ_STATUS) begin
      w1c_mask = reg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out <= '0;
      dir      <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
    end else if (reg_we) begin
      case (reg_addr)
        GPIO_ADDR_DATA_OUT: data_out <= reg_wdata;
        GPIO_ADDR_DIR:      dir      <= reg_wdata;
        GPIO_ADDR_RISE_EN:  rise_en  <= reg_wdata;
        GPIO_ADDR_FALL_EN:  fall_en  <= reg_wdata;
        GPIO_ADDR_DATA_SET: data_out <= data_out | reg_wdata;
        GPIO_ADDR_DATA_CLR: data_out <= data_out & ~reg_wdata;
        default:            ;
      endcase
    end
  end

  // New hits are ORed in after the clear so a same-cycle event is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status <= '0;
      irq    <= 1'b0;
    end else begin
      status <= (status & ~w1c_mask) | hit;
      irq    <= |status;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      GPIO_ADDR_DATA_OUT:   rd_mux = data_out;
      GPIO_ADDR_DIR:        rd_mux = dir;
      GPIO_ADDR_DATA_IN:    rd_mux = sync_in;
      GPIO_ADDR_RISE_EN:    rd_mux = rise_en;
      GPIO_ADDR_FALL_EN:    rd_mux = fall_en;
      GPIO_ADDR_IRQ_STATUS: rd_mux = status;
      default:              rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_rdata  <= '0;
      reg_rvalid <= 1'b0;
    end else begin
      reg_rvalid <= reg_re;
      if (reg_re) begin
        reg_rdata <= rd_mux;
      end
    end
  end

  assign gpio_out = data_out;
  assign gpio_oe  = dir;

endmodule

`default_nettype wire
